// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder.
//   - Gray-code state encodings for the {a, b} channel pair
//   - Direction constants used on the updown output
//   - Default synchronizer depth and glitch-filter length
//   - gray_next(): the next state in the "up" rotation
package quad_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILTER_LEN_DEF  = 4;

  // Up rotation is 00 -> 01 -> 11 -> 10 -> 00; down is the reverse.
  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_10 = 2'b10;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  function automatic logic [1:0] gray_next(input logic [1:0] s);
    case (s)
      ST_00:   return ST_01;
      ST_01:   return ST_11;
      ST_11:   return ST_10;
      default: return ST_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder channel: a SYNC_STAGES-deep synchronizer followed by a glitch
// filter. The filtered value only follows the synchronized value after the
// two have disagreed for FILTER_LEN consecutive clocks.
//
// Ports
//   clk    in   clock
//   reset  in   synchronous, active-high
//   din    in   raw asynchronous channel
//   dout   out  filtered channel value
//   valid  out  high once dout holds a real sample (not just the reset value)
module quad_filter
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic valid
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  // Travels alongside sync_q so we know when the synchronizer has flushed
  // its reset zeros and carries a genuine sample of din.
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   synced;
  logic [3:0]             cnt_q;
  logic                   filt_q;
  logic                   primed_q;

  assign synced = sync_q[SYNC_STAGES-1];

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, as real flops do.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // The first genuine synchronized sample seeds the filtered value
  // directly; it is only a reference for the decoder, never a transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      filt_q   <= 1'b0;
      primed_q <= 1'b0;
    end else if (!primed_q) begin
      cnt_q <= '0;
      if (fill_q[SYNC_STAGES-1]) begin
        filt_q   <= synced;
        primed_q <= 1'b1;
      end
    end else if (synced == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      // This is the FILTER_LEN-th consecutive disagreeing clock.
      filt_q <= synced;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign dout  = filt_q;
  assign valid = primed_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder, 4x mode, with a 4-bit wrapping position count.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high
//   enc_a     in   asynchronous encoder channel A
//   enc_b     in   asynchronous encoder channel B
//   load      in   load load_val into cont (wins over a step update)
//   load_val  in   [3:0] position preset
//   clr_err   in   clear the sticky err flag (a new illegal transition wins)
//   step      out  one-clock pulse per legal transition
//   updown    out  direction of the last step, 1 = up, 0 = down
//   cont      out  [3:0] position count
//   err       out  sticky: both channels changed at once
module quad_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clr_err,
  output logic       step,
  output logic       updown,
  output logic [3:0] cont,
  output logic       err
);

  logic       a_f, b_f;
  logic       a_vld, b_vld;
  logic [1:0] cur_state;
  logic [1:0] prev_state;
  logic       ref_valid;
  logic       dec_up, dec_dn, dec_bad;

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .din   (enc_a),
    .dout  (a_f),
    .valid (a_vld)
  );

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .din   (enc_b),
    .dout  (b_f),
    .valid (b_vld)
  );

  assign cur_state = {a_f, b_f};

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    dec_up  = 1'b0;
    dec_dn  = 1'b0;
    dec_bad = 1'b0;
    if (ref_valid && (cur_state != prev_state)) begin
      if (gray_next(prev_state) == cur_state)      dec_up  = 1'b1;
      else if (gray_next(cur_state) == prev_state) dec_dn  = 1'b1;
      else                                         dec_bad = 1'b1;
    end
  end

  // Decode reference. Both filters prime on the same clock, and that first
  // state is adopted silently. After that, every change (legal or not)
  // becomes the new reference.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_state <= ST_00;
      ref_valid  <= 1'b0;
    end else if (!ref_valid) begin
      if (a_vld && b_vld) begin
        prev_state <= cur_state;
        ref_valid  <= 1'b1;
      end
    end else begin
      prev_state <= cur_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step   <= 1'b0;
      updown <= UP;
    end else begin
      step <= dec_up | dec_dn;
      if (dec_up)      updown <= UP;
      else if (dec_dn) updown <= DOWN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       cont <= 4'h0;
    else if (load)   cont <= load_val;
    else if (dec_up) cont <= cont + 4'd1;
    else if (dec_dn) cont <= cont - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)        err <= 1'b0;
    else if (dec_bad) err <= 1'b1;
    else if (clr_err) err <= 1'b0;
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with default parameters. A table of
// encoder states walks the forward/reverse, preset, glitch and illegal
// cases; hand-written sequences cover exact-cycle corner cases.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       enc_a, enc_b;
  logic       load;
  logic [3:0] load_val;
  logic       clr_err;
  logic       step;
  logic       updown;
  logic [3:0] cont;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;
  int step_cnt = 0;

  always #5 clk = ~clk;

  quad_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .load     (load),
    .load_val (load_val),
    .clr_err  (clr_err),
    .step     (step),
    .updown   (updown),
    .cont     (cont),
    .err      (err)
  );

  typedef struct {
    logic [1:0] enc;
    logic       ld;
    logic [3:0] ld_val;
    logic       clr;
    int         hold;
    logic [3:0] exp_cont;
    logic       exp_ud;
    logic       exp_err;
    int         exp_steps;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic [1:0] enc, input logic ld,
                              input logic [3:0] ld_val, input logic clr,
                              input int hold, input logic [3:0] c,
                              input logic ud, input logic e, input int s);
    vec_t v;
    v.enc = enc; v.ld = ld; v.ld_val = ld_val; v.clr = clr; v.hold = hold;
    v.exp_cont = c; v.exp_ud = ud; v.exp_err = e; v.exp_steps = s;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (step) step_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_enc(input logic [1:0] e);
    enc_a = e[1];
    enc_b = e[0];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    vecs[0]  = mk(2'b00, 1'b0, 4'h0, 1'b0, 10, 4'h0, 1'b1, 1'b0, 0);
    vecs[1]  = mk(2'b01, 1'b0, 4'h0, 1'b0, 10, 4'h1, 1'b1, 1'b0, 1);
    vecs[2]  = mk(2'b11, 1'b0, 4'h0, 1'b0, 10, 4'h2, 1'b1, 1'b0, 1);
    vecs[3]  = mk(2'b10, 1'b0, 4'h0, 1'b0, 10, 4'h3, 1'b1, 1'b0, 1);
    vecs[4]  = mk(2'b00, 1'b0, 4'h0, 1'b0, 10, 4'h4, 1'b1, 1'b0, 1);
    vecs[5]  = mk(2'b00, 1'b1, 4'hE, 1'b0, 10, 4'hE, 1'b1, 1'b0, 0);
    vecs[6]  = mk(2'b01, 1'b0, 4'h0, 1'b0, 10, 4'hF, 1'b1, 1'b0, 1);
    vecs[7]  = mk(2'b11, 1'b0, 4'h0, 1'b0, 10, 4'h0, 1'b1, 1'b0, 1);
    vecs[8]  = mk(2'b10, 1'b0, 4'h0, 1'b0, 10, 4'h1, 1'b1, 1'b0, 1);
    vecs[9]  = mk(2'b11, 1'b0, 4'h0, 1'b0, 10, 4'h0, 1'b0, 1'b0, 1);
    vecs[10] = mk(2'b01, 1'b0, 4'h0, 1'b0, 10, 4'hF, 1'b0, 1'b0, 1);
    vecs[11] = mk(2'b11, 1'b0, 4'h0, 1'b0,  3, 4'hF, 1'b0, 1'b0, 0);
    vecs[12] = mk(2'b01, 1'b0, 4'h0, 1'b0, 10, 4'hF, 1'b0, 1'b0, 0);
    vecs[13] = mk(2'b11, 1'b0, 4'h0, 1'b0,  4, 4'hF, 1'b0, 1'b0, 0);
    vecs[14] = mk(2'b01, 1'b0, 4'h0, 1'b0, 12, 4'hF, 1'b0, 1'b0, 2);
    vecs[15] = mk(2'b00, 1'b0, 4'h0, 1'b0, 10, 4'hE, 1'b0, 1'b0, 1);
    vecs[16] = mk(2'b11, 1'b0, 4'h0, 1'b0, 10, 4'hE, 1'b0, 1'b1, 0);
    vecs[17] = mk(2'b11, 1'b0, 4'h0, 1'b1,  5, 4'hE, 1'b0, 1'b0, 0);

    reset = 1'b1; load = 1'b0; load_val = 4'h0; clr_err = 1'b0;
    set_enc(2'b00);
    ticks(3);
    check("reset cont",   int'(cont),   0);
    check("reset step",   int'(step),   0);
    check("reset updown", int'(updown), 1);
    check("reset err",    int'(err),    0);
    reset = 1'b0;

    // Table: first cycle carries the load/clr_err pulse, then hold.
    for (int i = 0; i < 18; i++) begin
      step_cnt = 0;
      set_enc(vecs[i].enc);
      load     = vecs[i].ld;
      load_val = vecs[i].ld_val;
      clr_err  = vecs[i].clr;
      tick();
      load    = 1'b0;
      clr_err = 1'b0;
      ticks(vecs[i].hold - 1);
      check($sformatf("vec%0d cont", i),   int'(cont),   int'(vecs[i].exp_cont));
      check($sformatf("vec%0d updown", i), int'(updown), int'(vecs[i].exp_ud));
      check($sformatf("vec%0d err", i),    int'(err),    int'(vecs[i].exp_err));
      check($sformatf("vec%0d steps", i),  step_cnt,     vecs[i].exp_steps);
    end

    // clr_err on the very edge a new illegal transition lands: set wins.
    step_cnt = 0;
    set_enc(2'b00);
    ticks(6);
    check("coinc err before", int'(err), 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("coinc err set wins", int'(err), 1);
    ticks(4);
    check("coinc err held", int'(err), 1);
    check("coinc steps", step_cnt, 0);
    check("coinc cont", int'(cont), 14);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr err", int'(err), 0);

    // Edge-to-step latency from the new reference 00.
    step_cnt = 0;
    lat = 0;
    set_enc(2'b01);
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (step && lat == 0) lat = n;
    end
    check("latency", lat, 7);
    check("latency cont", int'(cont), 15);
    check("latency updown", int'(updown), 1);
    check("latency steps", step_cnt, 1);

    // load on the step edge: load wins for cont, step/updown still pulse.
    set_enc(2'b11);
    ticks(6);
    load = 1'b1; load_val = 4'h5;
    tick();
    load = 1'b0;
    check("load+step step", int'(step), 1);
    check("load+step cont", int'(cont), 5);
    check("load+step updown", int'(updown), 1);
    ticks(5);

    // Encoder held at 11 through reset release: reference only.
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;
    step_cnt = 0;
    ticks(15);
    check("hold11 steps", step_cnt, 0);
    check("hold11 err", int'(err), 0);
    check("hold11 cont", int'(cont), 0);
    set_enc(2'b10);
    ticks(10);
    check("hold11 fwd steps", step_cnt, 1);
    check("hold11 fwd cont", int'(cont), 1);
    check("hold11 fwd updown", int'(updown), 1);

    // Reset 3 clocks after an edge aborts the pending transition.
    set_enc(2'b00);
    ticks(3);
    reset = 1'b1;
    tick();
    check("abort cont", int'(cont), 0);
    check("abort step", int'(step), 0);
    check("abort err", int'(err), 0);
    reset = 1'b0;
    step_cnt = 0;
    ticks(15);
    check("abort steps after", step_cnt, 0);
    check("abort cont after", int'(cont), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of input synchronizer flops per encoder channel (minimum 2).
REQ-002 Parameter FILTER_LEN, default 4, SHALL set the consecutive stable clocks a synchronized input needs before it is accepted (range 1-15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 enc_a, enc_b  input  1 each  SHALL be the asynchronous quadrature encoder channels.
REQ-006 load  input  1  SHALL load load_val into cont when high.
REQ-007 load_val  input  4  SHALL be the position preset value.
REQ-008 clr_err  input  1  SHALL clear the sticky err flag when high.
REQ-009 step  output  1  SHALL be a one-clock pulse for each decoded legal transition.
REQ-010 updown  output  1  SHALL give the direction of the last step: 1 = up, 0 = down.
REQ-011 cont  output  4  SHALL be the position count.
REQ-012 err  output  1  SHALL be a sticky flag for an illegal transition (both channels changing at once).

Function
REQ-013 Each channel SHALL pass through SYNC_STAGES flops and then a glitch filter.
- Filter counter increments each cycle the synchronized value differs from the filtered value.
- Any matching cycle clears the counter.
- Filtered value takes the synchronized value when the counter reaches FILTER_LEN.
REQ-014 Decoding SHALL use state {a_f,b_f} in 4x mode.
- Up: 00->01->11->10->00.
- Down: the reverse sequence.
- No change: no action.
- Both bits changing: illegal.
REQ-015 A legal transition SHALL raise step for exactly one cycle, registered one cycle after the filtered state changes; updown is updated on the same edge and held until the next step.
REQ-016 Latency from an enc_x edge to the step high cycle SHALL be SYNC_STAGES + FILTER_LEN + 1 clocks (7 with defaults).
REQ-017 cont SHALL update on the same edge that step rises.
- Up: +1, wrapping 15->0.
- Down: -1, wrapping 0->15.
REQ-018 Illegal transition SHALL set err on that edge, produce no step, and leave cont and updown unchanged; the new state becomes the decode reference.
REQ-019 Priority SHALL be reset > load > step update: load in a step cycle gives cont = load_val; step and updown still pulse as decoded.
REQ-020 clr_err and a new illegal transition in the same cycle SHALL leave err = 1 (set wins).
REQ-021 After reset, the first filtered state SHALL be taken as reference only: no step, no err, regardless of its value.

Reset
REQ-022 Reset SHALL force cont = 0, step = 0, updown = 1, err = 0.
REQ-023 Reset SHALL clear synchronizer flops, filter counters and filtered values, and clear the reference-valid bit.
REQ-024 Reset asserted mid-sequence SHALL abort pending filter counts; no step is issued for the aborted transition.

Structure
REQ-025 Package quad_pkg SHALL hold the four Gray state encodings, direction constants UP = 1 / DOWN = 0, and the SYNC_STAGES/FILTER_LEN defaults.
REQ-026 Sub-module quad_filter (synchronizer plus glitch filter, one channel) SHALL be instantiated twice; decode, count and error logic stay in quad_decoder.

Verification
REQ-027 Defaults, reset then enc 00; forward sequence, 10 clocks per state -> 4 step pulses, each 7 clocks after its edge; cont 0->1->2->3->4; updown = 1; err = 0.
REQ-028 load = 1, load_val = 0xE; then 3 forward steps -> cont 0xF, 0x0, 0x1; then 2 reverse steps -> cont 0x0, 0xF with updown = 0.
REQ-029 3-clock glitch on enc_a -> no step, cont unchanged; 4-clock pulse -> one up step then one down step, cont returns to its start value.
REQ-030 enc 00->11 simultaneously, held 10 clocks -> err = 1, no step, cont unchanged; clr_err pulse -> err = 0; clr_err coincident with a second illegal transition -> err stays 1.
REQ-031 Encoder held at 11 through reset release -> no err, no step, cont = 0; then 11->10 (forward) -> one up step, cont = 1.
REQ-032 Reset asserted 3 clocks after an enc edge -> cont = 0, step = 0, err = 0 next cycle; no step follows for that edge.
